pwm_controller_multi: RTL and testbench
=======================================

Name: pwm_controller_multi

Overview:
- Parametrised successor to the fixed 3-channel, 8-bit RGB PWM block. It provides N channels, a configurable counter width, a programmable period and a clock prescaler.
- Duty and period updates are double-buffered: new values reach the outputs only at a period boundary, so no output glitches or runt pulses occur.
- An optional fade mode ramps each channel's active duty toward its target, one step per period.
- Drives LED, backlight and motor-enable pins directly from the top level.

Parameters:
- CH, 3, number of PWM channels.
- WIDTH, 8, counter, period and duty width in bits.
- PRESC_W, 8, width of the prescaler divide register.
- FADE_STEP, 1, amount the active duty moves per period in fade mode (1 ≤ FADE_STEP < 2^WIDTH).
- OUT_INV, 0, when 1 all pwm_out bits are inverted (for active-low drivers).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- presc_div, in, PRESC_W: counter advances once every presc_div+1 clk cycles.
- period_in, in, WIDTH: period length is period_in+1 counts.
- duty_in, in, CH*WIDTH: packed duty targets; channel k occupies bits [k*WIDTH +: WIDTH].
- load, in, 1: one-cycle strobe that captures period_in and duty_in into the shadow registers.
- fade_en, in, 1: when 1, active duties ramp toward the shadow values; when 0, they jump.
- pwm_out, out, CH: PWM outputs.
- period_start, out, 1: one-cycle pulse when the counter wraps to 0.
- busy, out, 1: high while any active duty differs from its shadow, or a period update is pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - prescaler and counter are 0;
  - shadow and active period are 2^WIDTH-1;
  - shadow and active duties are 0;
  - pwm_out is all 0 (all 1 if OUT_INV=1);
  - period_start is 0 and busy is 0.
- Release from reset is synchronous; the first tick occurs presc_div+1 cycles after release.
- Prescaler:
  - presc_cnt counts 0..presc_div, and tick is asserted when presc_cnt == presc_div, after which it wraps to 0.
  - presc_div=0 gives a tick every cycle.
  - presc_div is sampled live, with no shadow register. If presc_div drops below presc_cnt, the prescaler wraps on the next cycle.
- Counter:
  - On tick, cnt advances to cnt+1, or to 0 when cnt == period_act.
  - wrap = tick && cnt == period_act. Counting is modulo period_act+1.
- Outputs:
  - pwm_out[k] is registered: it takes the value (cnt < duty_act[k]) ^ OUT_INV, one cycle after cnt changes.
  - duty_act = 0 gives a constant low output.
  - duty_act > period_act gives a constant high output. WIDTH-bit unsigned compare only.
- Load:
  - When load is high, shadow registers capture period_in and duty_in on that clock edge.
  - A later load before the next wrap overwrites the earlier one; the last write wins.
  - When load and wrap occur in the same cycle, the new shadow values are NOT applied at that wrap. They are applied at the following wrap.
- On wrap:
  - period_act takes period_sh.
  - If fade_en=0, duty_act[k] takes duty_sh[k].
  - If fade_en=1, duty_act[k] moves toward duty_sh[k] by FADE_STEP and clamps at the target with no overshoot. Arithmetic is WIDTH+1 bits, so there is no wrap-around.
  - period_start is pulsed in the same cycle that cnt becomes 0.
- Period shrink: if the new period_act is ≤ cnt at the moment of the update, no issue arises because the update happens only at wrap, when cnt returns to 0.
- Toggling fade_en mid-ramp takes effect at the next wrap.
- busy = (period_act != period_sh) || (any duty_act[k] != duty_sh[k]), registered.
- rst_n assertion mid-period forces the reset values immediately, without waiting for the clock.

Decomposition:
- Package pwm_pkg holds:
  - the default WIDTH/CH constants;
  - a function for the saturating step-toward-target;
  - the OUT_INV polarity helper.
- Sub-module pwm_fade_ch (one per channel, generate loop) holds:
  - duty_sh and duty_act;
  - the fade step logic and the compare-and-output register.
- The top level holds the prescaler, counter, period shadow and the busy OR-reduction.

Test Plan:
1. Reset, then load with period_in=9, presc_div=0, duty_in = {ch2=10, ch1=0, ch0=3}, fade_en=0.
   - After the first wrap the period is 10 cycles.
   - ch0 is high for 3 cycles, ch1 is constantly low, ch2 is constantly high.
   - period_start pulses every 10 cycles.
2. presc_div=3 with period_in=3: period_start pulses every 16 clk cycles, and pwm_out transitions align to tick boundaries.
3. Mid-period load changing ch0 from 3 to 7:
   - The current period still shows 3 high counts; the next period shows 7.
   - A second load with duty 5 before the wrap results in 5.
   - load coincident with wrap: the new value appears one period later.
4. fade_en=1, FADE_STEP=2, duty_act=0, target=5:
   - duty_act goes 2, 4, 5 over three wraps.
   - busy drops in the cycle after duty_act reaches 5.
   - Target lowered to 1: duty_act goes 3, 1.
5. OUT_INV=1, duty 0: pwm_out is constantly high, including during reset.
6. Assert rst_n low mid-period with nonzero cnt: all outputs go to reset values asynchronously, and after release the counter restarts from 0 with period 2^WIDTH.

Source files
------------

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helpers for the multi-channel PWM controller.
//   DEF_CH / DEF_WIDTH / DEF_PRESC_W : default channel count and widths
//   step_toward()    : saturating move of a value toward a target
//   apply_polarity() : optional output inversion for active-low drivers
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int DEF_CH      = 3;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 8;

    // Moves cur toward tgt by at most step and never past tgt.
    // Operands are zero-extended WIDTH-bit values, so the 33-bit sum
    // cannot wrap for any supported WIDTH (<= 31).
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (cur < tgt) begin
            return (sum > {1'b0, tgt}) ? tgt : sum[31:0];
        end else if (cur > tgt) begin
            return ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return tgt;
    endfunction

    function automatic logic apply_polarity(input logic level, input logic inv);
        return level ^ inv;
    endfunction

endpackage

// File: rtl/pwm_fade_ch.sv
// ---------------------------------------------------------------------------
// pwm_fade_ch
// One PWM channel: shadow and active duty, optional fade ramp and the
// registered compare output.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : capture duty_in into the shadow register
//   duty_in       : new duty target for this channel
//   wrap          : period boundary, the only moment duty_act may change
//   fade_en       : 1 = ramp duty_act toward shadow, 0 = jump
//   cnt           : shared period counter
//   pwm_out       : registered PWM output (polarity applied)
//   duty_pending  : active duty differs from its shadow
// ---------------------------------------------------------------------------
module pwm_fade_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FADE_STEP = 1,
    parameter bit OUT_INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             wrap,
    input  logic             fade_en,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm_out,
    output logic             duty_pending
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] duty_next;

    // Value duty_act takes at the next wrap.
    always_comb begin
        duty_next = duty_sh;
        if (fade_en) begin
            duty_next = WIDTH'(step_toward(32'(duty_act), 32'(duty_sh), 32'(FADE_STEP)));
        end
    end

    // A load coincident with wrap lands here only; duty_act still sees the
    // old shadow on that edge, so the new value waits one more period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
        end else if (load) begin
            duty_sh <= duty_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act <= '0;
        end else if (wrap) begin
            duty_act <= duty_next;
        end
    end

    // Plain unsigned compare: duty 0 is always low, duty above the period
    // is always high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= OUT_INV;
        end else begin
            pwm_out <= apply_polarity(cnt < duty_act, OUT_INV);
        end
    end

    assign duty_pending = (duty_act != duty_sh);

endmodule

// File: rtl/pwm_controller_multi.sv
// ---------------------------------------------------------------------------
// pwm_controller_multi
// N-channel PWM generator with prescaler, programmable period and
// double-buffered period/duty updates applied at the period boundary.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   presc_div     : counter advances every presc_div+1 clk cycles (live)
//   period_in     : period length is period_in+1 counts
//   duty_in       : packed duties, channel k at [k*WIDTH +: WIDTH]
//   load          : strobe capturing period_in/duty_in into shadows
//   fade_en       : ramp active duties toward shadow instead of jumping
//   pwm_out       : PWM outputs, one per channel
//   period_start  : one-cycle pulse as the counter returns to 0
//   busy          : an update is still pending or a ramp is in progress
// ---------------------------------------------------------------------------
module pwm_controller_multi
    import pwm_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PRESC_W   = DEF_PRESC_W,
    parameter int FADE_STEP = 1,
    parameter bit OUT_INV   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PRESC_W-1:0]  presc_div,
    input  logic [WIDTH-1:0]    period_in,
    input  logic [CH*WIDTH-1:0] duty_in,
    input  logic                load,
    input  logic                fade_en,
    output logic [CH-1:0]       pwm_out,
    output logic                period_start,
    output logic                busy
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               wrap;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   period_sh;
    logic [WIDTH-1:0]   period_act;
    logic [CH-1:0]      duty_pending;

    assign tick = (presc_cnt == presc_div);
    assign wrap = tick && (cnt == period_act);

    // presc_div is used live; if it is lowered below presc_cnt the
    // prescaler simply restarts on the next cycle without a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= presc_div) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    // The period only changes at wrap, when cnt is returning to 0, so a
    // shrinking period can never strand cnt above period_act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh  <= '1;
            period_act <= '1;
        end else begin
            if (load) begin
                period_sh <= period_in;
            end
            if (wrap) begin
                period_act <= period_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period_start <= wrap;
            busy         <= (period_act != period_sh) || (|duty_pending);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pwm_fade_ch #(
            .WIDTH     (WIDTH),
            .FADE_STEP (FADE_STEP),
            .OUT_INV   (OUT_INV)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .load         (load),
            .duty_in      (duty_in[k*WIDTH +: WIDTH]),
            .wrap         (wrap),
            .fade_en      (fade_en),
            .cnt          (cnt),
            .pwm_out      (pwm_out[k]),
            .duty_pending (duty_pending[k])
        );
    end

endmodule

// File: tb/tb_pwm_controller_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_controller_multi
// Two instances share all inputs: "a" (FADE_STEP=2, normal polarity) and
// "b" (FADE_STEP=1, inverted outputs). A behavioural model predicts both
// every cycle; per-period windows of the "a" outputs pin the model with
// hand-computed high-time counts.
// ---------------------------------------------------------------------------
module tb_pwm_controller_multi;

    localparam int CH = 3;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    presc_div = '0;
    logic [W-1:0]  period_in = '0;
    logic [23:0]   duty_in   = '0;
    logic          load      = 1'b0;
    logic          fade_en   = 1'b0;

    logic [CH-1:0] pwm_a, pwm_b;
    logic          start_a, start_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_controller_multi #(.CH(CH), .WIDTH(W), .PRESC_W(8), .FADE_STEP(2), .OUT_INV(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .presc_div(presc_div), .period_in(period_in),
        .duty_in(duty_in), .load(load), .fade_en(fade_en),
        .pwm_out(pwm_a), .period_start(start_a), .busy(busy_a));

    pwm_controller_multi #(.CH(CH), .WIDTH(W), .PRESC_W(8), .FADE_STEP(1), .OUT_INV(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .presc_div(presc_div), .period_in(period_in),
        .duty_in(duty_in), .load(load), .fade_en(fade_en),
        .pwm_out(pwm_b), .period_start(start_b), .busy(busy_b));

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_presc, m_cnt, m_pact, m_psh;
    int m_dsh[CH];
    int m_dact[2][CH];
    bit e_pwm[2][CH];
    bit e_start;
    bit e_busy[2];
    int step_of[2] = '{2, 1};
    bit inv_of[2]  = '{1'b0, 1'b1};

    function automatic int ramp(input int cur, input int tgt, input int stp);
        int d;
        d = tgt - cur;
        if (d > stp) d = stp;
        else if (d < -stp) d = -stp;
        return cur + d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc = 0; m_cnt = 0; m_pact = 255; m_psh = 255;
            e_start = 1'b0;
            for (int k = 0; k < CH; k++) begin
                m_dsh[k] = 0;
                for (int i = 0; i < 2; i++) begin
                    m_dact[i][k] = 0;
                    e_pwm[i][k]  = inv_of[i];
                end
            end
            e_busy[0] = 1'b0;
            e_busy[1] = 1'b0;
        end else begin
            bit ticked, wrapped;
            ticked  = (m_presc == int'(presc_div));
            wrapped = ticked && (m_cnt == m_pact);
            for (int i = 0; i < 2; i++) begin
                e_busy[i] = (m_pact != m_psh);
                for (int k = 0; k < CH; k++) begin
                    e_pwm[i][k] = (m_cnt < m_dact[i][k]) ^ inv_of[i];
                    if (m_dact[i][k] != m_dsh[k]) e_busy[i] = 1'b1;
                end
            end
            e_start = wrapped;
            m_presc = (m_presc >= int'(presc_div)) ? 0 : m_presc + 1;
            if (ticked) m_cnt = wrapped ? 0 : m_cnt + 1;
            if (wrapped) begin
                m_pact = m_psh;
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < CH; k++)
                        m_dact[i][k] = fade_en ? ramp(m_dact[i][k], m_dsh[k], step_of[i]) : m_dsh[k];
            end
            if (load) begin
                m_psh = int'(period_in);
                for (int k = 0; k < CH; k++) m_dsh[k] = int'(duty_in[k*W +: W]);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < CH; k++) begin
            check_output($sformatf("pwm_a[%0d]", k), int'(pwm_a[k]), int'(e_pwm[0][k]));
            check_output($sformatf("pwm_b[%0d]", k), int'(pwm_b[k]), int'(e_pwm[1][k]));
        end
        check_output("period_start_a", int'(start_a), int'(e_start));
        check_output("period_start_b", int'(start_b), int'(e_start));
        check_output("busy_a", int'(busy_a), int'(e_busy[0]));
        check_output("busy_b", int'(busy_b), int'(e_busy[1]));
    end

    // ---------------- per-period window monitor (instance a) ----------------
    // Window i opens at period_start number i and covers the following
    // samples up to and including the next period_start, i.e. the outputs
    // for cnt = 0..period (pwm lags cnt by one cycle).
    int  starts = 0;
    bit  active = 1'b0;
    int  win_len;
    int  win_hi[CH];
    int  rec_len[1024];
    int  rec_hi[1024][CH];

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            if (active) begin
                win_len++;
                for (int k = 0; k < CH; k++) win_hi[k] += int'(pwm_a[k]);
            end
            if (start_a) begin
                if (active && starts > 0 && starts <= 1024) begin
                    rec_len[starts-1] = win_len;
                    for (int k = 0; k < CH; k++) rec_hi[starts-1][k] = win_hi[k];
                end
                starts++;
                active  = 1'b1;
                win_len = 0;
                for (int k = 0; k < CH; k++) win_hi[k] = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int per, input int d2, input int d1, input int d0);
        period_in = W'(per);
        duty_in   = {W'(d2), W'(d1), W'(d0)};
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic wait_start(output int idx);
        int n0;
        int budget;
        n0 = starts;
        budget = 0;
        while (starts == n0 && budget < 700) begin
            step();
            budget++;
        end
        check_output("wait_start_seen", int'(starts != n0), 1);
        idx = (starts > 0) ? starts - 1 : 0;
    endtask

    task automatic wait_complete(input int idx);
        int budget;
        budget = 0;
        while (starts < idx + 2 && budget < 1500) begin
            step();
            budget++;
        end
        check_output("wait_complete_seen", int'(starts >= idx + 2), 1);
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int idx, idx0, idx1, idx2, idx3, cyc;
        bit all_high;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) step();
        check_output("reset_pwm_a", int'(pwm_a), 0);
        check_output("reset_pwm_b_inv", int'(pwm_b), 7);
        check_output("reset_start", int'(start_a), 0);
        check_output("reset_busy", int'(busy_a), 0);
        rst_n = 1'b1;

        // 1: period 9, duties {10,0,3}, no prescale
        presc_div = 8'd0;
        apply_stimulus(9, 10, 0, 3);
        step();
        check_output("busy_after_load", int'(busy_a), 1);
        wait_start(idx);
        all_high = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pwm_b[1] !== 1'b1) all_high = 1'b0;
        end
        check_output("inv_duty0_const_high", int'(all_high), 1);
        wait_complete(idx + 1);
        check_output("t1_len", rec_len[idx], 10);
        check_output("t1_len_next", rec_len[idx+1], 10);
        check_output("t1_ch0_hi", rec_hi[idx][0], 3);
        check_output("t1_ch1_hi", rec_hi[idx][1], 0);
        check_output("t1_ch2_hi", rec_hi[idx][2], 10);

        // 2: prescale by 4, period 3 -> 16 clk cycles per period
        presc_div = 8'd3;
        apply_stimulus(3, 10, 0, 3);
        wait_start(idx);
        wait_complete(idx);
        check_output("t2_len", rec_len[idx], 16);
        check_output("t2_ch0_hi", rec_hi[idx][0], 12);
        check_output("t2_ch1_hi", rec_hi[idx][1], 0);
        check_output("t2_ch2_hi", rec_hi[idx][2], 16);

        // 3: mid-period loads
        presc_div = 8'd0;
        apply_stimulus(9, 10, 0, 3);
        wait_start(idx);
        wait_start(idx);
        repeat (3) step();
        apply_stimulus(9, 10, 0, 7);
        wait_complete(idx + 1);
        check_output("t3_cur_period", rec_hi[idx][0], 3);
        check_output("t3_next_period", rec_hi[idx+1][0], 7);

        wait_start(idx);
        repeat (2) step();
        apply_stimulus(9, 10, 0, 7);
        repeat (2) step();
        apply_stimulus(9, 10, 0, 5);
        wait_complete(idx + 1);
        check_output("t3_before_last_wins", rec_hi[idx][0], 7);
        check_output("t3_last_wins", rec_hi[idx+1][0], 5);

        wait_start(idx);
        repeat (9) step();
        apply_stimulus(9, 10, 0, 2);
        wait_complete(idx + 2);
        check_output("t3_coinc_cur", rec_hi[idx][0], 5);
        check_output("t3_coinc_held", rec_hi[idx+1][0], 5);
        check_output("t3_coinc_applied", rec_hi[idx+2][0], 2);

        // 4: fade 0 -> 5 with step 2, then back down to 1
        apply_stimulus(9, 10, 0, 0);
        wait_start(idx0);
        wait_start(idx0);
        repeat (2) step();
        fade_en = 1'b1;
        apply_stimulus(9, 10, 0, 5);
        wait_start(idx1);
        wait_start(idx2);
        wait_start(idx3);
        check_output("t4_busy_at_reach", int'(busy_a), 1);
        step();
        check_output("t4_busy_dropped", int'(busy_a), 0);
        apply_stimulus(9, 10, 0, 1);
        wait_complete(idx3 + 2);
        check_output("t4_ramp_0", rec_hi[idx0][0], 0);
        check_output("t4_ramp_1", rec_hi[idx1][0], 2);
        check_output("t4_ramp_2", rec_hi[idx2][0], 4);
        check_output("t4_ramp_3", rec_hi[idx3][0], 5);
        check_output("t4_down_1", rec_hi[idx3+1][0], 3);
        check_output("t4_down_2", rec_hi[idx3+2][0], 1);
        fade_en = 1'b0;

        // 6: asynchronous reset mid-period
        wait_start(idx);
        repeat (4) step();
        check_output("t6_pre_pwm_ch2", int'(pwm_a[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6_async_pwm_a", int'(pwm_a), 0);
        check_output("t6_async_pwm_b", int'(pwm_b), 7);
        check_output("t6_async_start", int'(start_a), 0);
        check_output("t6_async_busy", int'(busy_a), 0);
        repeat (2) step();
        rst_n = 1'b1;
        cyc = 0;
        while (start_a !== 1'b1 && cyc < 600) begin
            step();
            cyc++;
        end
        check_output("t6_first_wrap_cycles", cyc, 256);
        idx = (starts > 0) ? starts - 1 : 0;
        wait_complete(idx);
        check_output("t6_period_len", rec_len[idx], 256);
        check_output("t6_duty_reset", rec_hi[idx][2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
